// File: rtl/fp32_pkg.sv
// Shared binary32 constants and the post-normalisation FSM state type.
// Pure declarations; no logic, no latency.
// Not applicable: no handshake lives here.
package fp32_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } postnorm_state_t;

    localparam int FP32_EXP_W   = 8;
    localparam int FP32_FRAC_W  = 23;
    localparam int FP32_EXP_MAX = 255;
    localparam int FP32_BIAS    = 127;

    localparam logic [31:0] FP32_POS_INF  = 32'h7F80_0000;
    localparam logic [31:0] FP32_NEG_ZERO = 32'h8000_0000;

endpackage

// File: rtl/fp32_round.sv
// Rounds a normalised 24-bit significand and flags exponent overflow.
// Purely combinational, zero cycles.
// No handshake; the caller samples the outputs in its ROUND state.
// Rounding mode: FP32_ROUND_NEAREST_EN defined -> nearest-even, else toward zero.
module fp32_round
    import fp32_pkg::*;
(
    input  logic [23:0] sig_i,
    input  logic        guard_i,
    input  logic        sticky_i,
    input  logic [8:0]  exp_i,
    output logic [22:0] frac_o,
    output logic [8:0]  exp_o,
    output logic        ovf_o
);

    logic round_up;
    logic carry;

`ifdef FP32_ROUND_NEAREST_EN
    assign round_up = guard_i & (sticky_i | sig_i[0]);
`else
    // Truncation: guard and sticky are still delivered but deliberately unused.
    logic unused_gs;
    assign unused_gs = guard_i ^ sticky_i;
    assign round_up  = 1'b0;
`endif

    // Incrementing an all-ones significand wraps the fraction to zero and
    // bumps the exponent, which is exactly 1.000... at the next binade.
    assign carry  = round_up & (&sig_i);
    assign frac_o = sig_i[22:0] + {22'b0, round_up};
    assign exp_o  = exp_i + {8'b0, carry};
    assign ovf_o  = (exp_o >= 9'(FP32_EXP_MAX));

endmodule

// File: rtl/fp32_postnorm.sv
// Post-normalise (one left shift per cycle), round and pack an fp32 adder result.
// Latency: zero 1, normalised/carry 2, N shifts 2+N, underflow after k shifts 2+k.
// start is ignored while busy; result/ovf/unf hold until the next done.
module fp32_postnorm
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sign,
    input  logic [7:0]  exp_in,
    input  logic [26:0] mant_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        ovf,
    output logic        unf
);

    postnorm_state_t state_q, state_d;
    logic        sign_q, sign_d;
    logic [8:0]  exp_q, exp_d;
    logic [26:0] mant_q, mant_d;
    logic [31:0] result_q, result_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;

    logic [22:0] rnd_frac;
    logic [8:0]  rnd_exp;
    logic        rnd_ovf;

    fp32_round u_round (
        .sig_i    (mant_q[25:2]),
        .guard_i  (mant_q[1]),
        .sticky_i (mant_q[0]),
        .exp_i    (exp_q),
        .frac_o   (rnd_frac),
        .exp_o    (rnd_exp),
        .ovf_o    (rnd_ovf)
    );

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Next-state and datapath: normalise, round, pack; outputs change only on entry to DONE.
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sign_d = sign;
                    exp_d  = {1'b0, exp_in};
                    mant_d = mant_in;
                    if (mant_in == 27'd0) begin
                        result_d = sign ? FP32_NEG_ZERO : 32'h0;
                        ovf_d    = 1'b0;
                        unf_d    = 1'b0;
                        state_d  = ST_DONE;
                    end else if (mant_in[26]) begin
                        // Fold the dropped bit into sticky so rounding still sees it.
                        mant_d  = {1'b0, mant_in[26:2], mant_in[1] | mant_in[0]};
                        exp_d   = {1'b0, exp_in} + 9'd1;
                        state_d = ST_ROUND;
                    end else if (mant_in[25]) begin
                        state_d = ST_ROUND;
                    end else begin
                        state_d = ST_NORM;
                    end
                end
            end
            ST_NORM: begin
                // Exponent 0 is treated like 1 so a zero-exponent input cannot wrap.
                if (exp_q <= 9'd1) begin
                    result_d = {sign_q, 31'b0};
                    ovf_d    = 1'b0;
                    unf_d    = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    mant_d = {mant_q[25:0], 1'b0};
                    exp_d  = exp_q - 9'd1;
                    if (mant_q[24]) begin
                        state_d = ST_ROUND;
                    end
                end
            end
            ST_ROUND: begin
                if (rnd_ovf) begin
                    result_d = {sign_q, FP32_POS_INF[30:0]};
                end else begin
                    result_d = {sign_q, rnd_exp[7:0], rnd_frac};
                end
                ovf_d   = rnd_ovf;
                unf_d   = 1'b0;
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign ovf    = ovf_q;
    assign unf    = unf_q;

endmodule

// File: tb/tb_fp32_postnorm.sv
// Directed-vector bench for fp32_postnorm with an arithmetic reference model.
// Checks reset state, latency, results, flags, ignored starts and mid-op reset.
// Rounding expectations follow FP32_ROUND_NEAREST_EN.
`timescale 1ns/1ps
module tb_fp32_postnorm;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sign;
    logic [7:0]  exp_in;
    logic [26:0] mant_in;
    logic        busy, done, ovf, unf;
    logic [31:0] result;

    fp32_postnorm dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .sign    (sign),
        .exp_in  (exp_in),
        .mant_in (mant_in),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .ovf     (ovf),
        .unf     (unf)
    );

    always #5 clk = ~clk;

`ifdef FP32_ROUND_NEAREST_EN
    localparam bit NEAREST = 1'b1;
    localparam logic [31:0] LIT_RND_ALL1 = 32'h4000_0000;
    localparam logic [31:0] LIT_RND_ODD  = 32'h3F80_0002;
    localparam logic [31:0] LIT_CARRY_ST = 32'h4000_0001;
`else
    localparam bit NEAREST = 1'b0;
    localparam logic [31:0] LIT_RND_ALL1 = 32'h3FFF_FFFF;
    localparam logic [31:0] LIT_RND_ODD  = 32'h3F80_0001;
    localparam logic [31:0] LIT_CARRY_ST = 32'h4000_0000;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Expected-transaction state shared between driver and compare process.
    bit          op_active = 1'b0;
    int          due;
    logic [31:0] exp_res;
    bit          exp_ovf, exp_unf;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: find the leading one arithmetically, count shifts against the
    // exponent floor, then round with integer arithmetic.
    task automatic model(input bit s, input int e_in, input logic [26:0] m_in,
                         output logic [31:0] r, output bit ov, output bit un, output int lat);
        longint m;
        longint sig;
        int     e, n, k;
        bit     g, st, rup;
        m  = longint'(m_in);
        e  = e_in;
        ov = 1'b0;
        un = 1'b0;
        if (m == 0) begin
            r   = {s, 31'b0};
            lat = 1;
            return;
        end
        if (m >= (64'd1 << 26)) begin
            m   = (m >> 1) | (m & 1);
            e   = e + 1;
            lat = 2;
        end else begin
            n = 0;
            while (m < (64'd1 << 25)) begin
                m = m * 2;
                n++;
            end
            if (e - n < 1) begin
                k   = (e > 1) ? e - 1 : 0;
                r   = {s, 31'b0};
                un  = 1'b1;
                lat = 2 + k;
                return;
            end
            e   = e - n;
            lat = 2 + n;
        end
        g   = m[1];
        st  = m[0];
        sig = m >> 2;
        rup = NEAREST ? (g & (st | sig[0])) : 1'b0;
        sig = sig + longint'(rup);
        if (sig >= (64'd1 << 24)) begin
            sig = 64'd1 << 23;
            e   = e + 1;
        end
        if (e >= 255) begin
            r  = {s, 8'hFF, 23'b0};
            ov = 1'b1;
        end else begin
            r = {s, e[7:0], sig[22:0]};
        end
    endtask

    // Compare process: every cycle an operation is outstanding.
    always @(negedge clk) begin
        if (!rst && op_active) begin
            if (cyc == due) begin
                check("done_pulse", {31'b0, done}, 32'd1);
                check("result", result, exp_res);
                check("ovf", {31'b0, ovf}, {31'b0, exp_ovf});
                check("unf", {31'b0, unf}, {31'b0, exp_unf});
                op_active = 1'b0;
            end else begin
                check("done_early", {31'b0, done}, 32'd0);
                check("busy_inflight", {31'b0, busy}, 32'd1);
            end
        end
    end

    task automatic run_op(input string nm, input bit s, input logic [7:0] e, input logic [26:0] m,
                          input logic [31:0] lit_res, input int lit_lat,
                          input bit lit_ovf, input bit lit_unf, input int poke);
        logic [31:0] r;
        bit ov, un;
        int lat;
        model(s, int'(e), m, r, ov, un, lat);
        check({nm, "_model_res"}, r, lit_res);
        check({nm, "_model_lat"}, lat, lit_lat);
        check({nm, "_model_flags"}, {30'b0, ov, un}, {30'b0, lit_ovf, lit_unf});
        @(negedge clk); #1;
        start   = 1'b1;
        sign    = s;
        exp_in  = e;
        mant_in = m;
        exp_res = r;
        exp_ovf = ov;
        exp_unf = un;
        due     = cyc + lat;
        op_active = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i < 40 && op_active; i++) begin
            if (i == poke) begin
                start   = 1'b1;
                sign    = ~s;
                exp_in  = 8'd0;
                mant_in = 27'h400_0000;
            end else begin
                start = 1'b0;
            end
            @(negedge clk); #1;
        end
        start = 1'b0;
        if (op_active) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_done required=done_after_%0d", nm, lat);
            op_active = 1'b0;
        end
        @(negedge clk); #1;
        check({nm, "_idle_busy"}, {31'b0, busy}, 32'd0);
        check({nm, "_idle_done"}, {31'b0, done}, 32'd0);
        check({nm, "_held"}, result, r);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sign = 1'b0; exp_in = '0; mant_in = '0;
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", {30'b0, ovf, unf}, 32'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        run_op("norm",     1'b0, 8'd127, 27'h200_0000, 32'h3F80_0000, 2, 1'b0, 1'b0, 0);
        run_op("carry",    1'b0, 8'd127, 27'h400_0000, 32'h4000_0000, 2, 1'b0, 1'b0, 0);
        run_op("shift3",   1'b0, 8'd130, 27'h040_0000, 32'h3F80_0000, 5, 1'b0, 1'b0, 2);
        run_op("zero",     1'b1, 8'd77,  27'h000_0000, 32'h8000_0000, 1, 1'b0, 1'b0, 0);
        run_op("underflow",1'b0, 8'd2,   27'h010_0000, 32'h0000_0000, 3, 1'b0, 1'b1, 0);
        run_op("rnd_all1", 1'b0, 8'd127, {1'b0, 1'b1, {23{1'b1}}, 1'b1, 1'b0}, LIT_RND_ALL1, 2, 1'b0, 1'b0, 0);
        run_op("rnd_odd",  1'b0, 8'd127, 27'h200_0006, LIT_RND_ODD, 2, 1'b0, 1'b0, 0);
        run_op("rnd_tie",  1'b0, 8'd127, 27'h200_0002, 32'h3F80_0000, 2, 1'b0, 1'b0, 0);
        run_op("carry_st", 1'b0, 8'd127, 27'h400_0005, LIT_CARRY_ST, 2, 1'b0, 1'b0, 0);
        run_op("ovf",      1'b0, 8'd254, 27'h400_0000, 32'h7F80_0000, 2, 1'b1, 1'b0, 0);
        run_op("exp255",   1'b1, 8'd255, 27'h200_0000, 32'hFF80_0000, 2, 1'b1, 1'b0, 0);
        run_op("shift24",  1'b0, 8'd127, 27'h000_0002, 32'h3380_0000, 26, 1'b0, 1'b0, 0);

        // Reset during NORM: outputs clear immediately and no done follows.
        @(negedge clk); #1;
        start = 1'b1; sign = 1'b0; exp_in = 8'd130; mant_in = 27'h040_0000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_done", {31'b0, done}, 32'd0);
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_flags", {30'b0, ovf, unf}, 32'd0);
        @(negedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            check("post_rst_no_done", {30'b0, done, busy}, 32'd0);
        end
        run_op("after_rst", 1'b0, 8'd130, 27'h040_0000, 32'h3F80_0000, 5, 1'b0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
